// File: rtl/sliding_window_kxk.sv
// sliding_window_kxk: K x K sliding-window generator for a raster pixel stream.
// It holds K-1 internal line buffers. It emits one window per accepted pixel
// once the window lies fully inside the image ("valid" convolution, no padding).
// Input and output use valid/ready handshakes. A stalled output stops the input.
// Optional feature macro: SLIDING_WINDOW_SOF_EN. When defined, it adds a sof
// input that forces the accepted pixel to frame position (0,0).
module sliding_window_kxk #(
  parameter int DATA_W = 8,
  parameter int K      = 3,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef SLIDING_WINDOW_SOF_EN
  input  logic                       sof,
`endif
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       win_valid,
  input  logic                       win_ready,
  output logic [K*K*DATA_W-1:0]      win_data,
  output logic [$clog2(IMG_H)-1:0]   win_row,
  output logic [$clog2(IMG_W)-1:0]   win_col
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  // Frame position of the next pixel to be accepted.
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;

  // Effective position of the pixel currently offered; sof may override it.
  logic [COL_W-1:0]  pix_col;
  logic [ROW_W-1:0]  pix_row;

  // lb[0] is the previous row, lb[K-2] the oldest row.
  logic [DATA_W-1:0] lb [K-1][IMG_W];
  logic [DATA_W-1:0] win_q [K][K];
  logic [DATA_W-1:0] new_col [K];

  logic accept;
  logic completes;
  logic last_col;
  logic last_row;

`ifdef SLIDING_WINDOW_SOF_EN
  assign pix_col = sof ? '0 : col_q;
  assign pix_row = sof ? '0 : row_q;
`else
  assign pix_col = col_q;
  assign pix_row = row_q;
`endif

  assign in_ready  = !win_valid || win_ready;
  assign accept    = in_valid && in_ready;
  assign completes = (pix_row >= ROW_W'(K-1)) && (pix_col >= COL_W'(K-1));
  assign last_col  = (pix_col == COL_W'(IMG_W-1));
  assign last_row  = (pix_row == ROW_W'(IMG_H-1));

  // Build the incoming window column from the line buffers and the new pixel, top to bottom.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    for (int r = 0; r < K; r++) new_col[r] = '0;
    for (int r = 0; r < K-1; r++) new_col[r] = lb[K-2-r][pix_col];
    new_col[K-1] = in_data;
  end

  // Push the accepted pixel into lb[0] and age the older rows one buffer down at this column.
  always_ff @(posedge clk) begin
    // NOTE: the line-buffer RAM is deliberately not reset, so it maps onto plain
    // memory. Stale rows are never presented because windows need row >= K-1.
    if (accept) begin
      lb[0][pix_col] <= in_data;
      for (int i = 1; i < K-1; i++) lb[i][pix_col] <= lb[i-1][pix_col];
    end
  end

  // Window shift register, frame counters and output handshake state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every read
    // in this block sees the pre-edge value, independent of statement order.
    if (rst) begin
      col_q     <= '0;
      row_q     <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K-1; c++) win_q[r][c] <= win_q[r][c+1];
        win_q[r][K-1] <= new_col[r];
      end
      if (last_col) begin
        col_q <= '0;
        row_q <= last_row ? '0 : pix_row + ROW_W'(1);
      end else begin
        col_q <= pix_col + COL_W'(1);
        row_q <= pix_row;
      end
      win_valid <= completes;
      if (completes) begin
        win_row <= pix_row;
        win_col <= pix_col;
      end
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

  // Flatten the window: element (r,c) at [(r*K+c)*DATA_W +: DATA_W].
  for (genvar gr = 0; gr < K; gr++) begin : g_row
    for (genvar gc = 0; gc < K; gc++) begin : g_col
      assign win_data[(gr*K+gc)*DATA_W +: DATA_W] = win_q[gr][gc];
    end
  end

endmodule
